// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline forwarding / hazard unit.
// Tracked destination addresses are stored zero-extended to HZ_RD_W bits so
// that one entry type serves every REG_ADDR_W up to that width.
package hazard_pkg;

    localparam int HZ_RD_W          = 8;
    localparam int ZERO_REG_DEFAULT = 31;
    localparam int X30              = 30;

    // One in-flight instruction past decode.
    typedef struct packed {
        logic               valid;
        logic [HZ_RD_W-1:0] rd;
        logic               wr;
        logic               load;
    } hz_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Per-source comparator and priority encoder over the tracked-stage array.
// Index 0 of entries is stage 1 (EX); the youngest (lowest) matching stage
// wins. load_hit flags that this youngest match is a load whose data is not
// yet forwardable (stage <= LOAD_LAT).
module hazard_match
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int ZERO_REG   = ZERO_REG_DEFAULT,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  hz_entry_t [NUM_STAGES-1:0] entries,
    input  logic      [REG_ADDR_W-1:0] src,
    output logic      [SEL_W-1:0]      sel,
    output logic                       load_hit
);

    logic [HZ_RD_W-1:0]    src_ext;
    logic                  src_is_zero;
    logic [NUM_STAGES-1:0] hit;

    assign src_ext     = HZ_RD_W'(src);
    assign src_is_zero = (src == REG_ADDR_W'(ZERO_REG));

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_cmp
            assign hit[gi] = entries[gi].valid && entries[gi].wr &&
                             (entries[gi].rd == src_ext) && !src_is_zero;
        end
    endgenerate

    // Scan oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
        sel      = '0;
        load_hit = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel      = SEL_W'(k + 1);
                load_hit = entries[k].load && ((k + 1) <= LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Forwarding and hazard-control unit: tracks destination registers of the
// NUM_STAGES instructions past decode and derives forward selects and the
// load-use stall. Optional performance counters (stall_count, fwd_count)
// are built when the macro HAZARD_PERF_EN is defined.
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int ZERO_REG   = ZERO_REG_DEFAULT,
    localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rn,
    input  logic [REG_ADDR_W-1:0] dec_rm,
    input  logic                  dec_rm_used,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_wr,
    input  logic                  dec_load,
    input  logic                  flush,
    output logic [SEL_W-1:0]      fwd_sel_a,
    output logic [SEL_W-1:0]      fwd_sel_b,
`ifdef HAZARD_PERF_EN
    output logic [31:0]           stall_count,
    output logic [31:0]           fwd_count,
`endif
    output logic                  stall
);

    hz_entry_t [NUM_STAGES-1:0] stage_reg;
    hz_entry_t                  dec_entry;

    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             load_hit_a;
    logic             load_hit_b;
    logic             hazard;

    hazard_match #(
        .NUM_STAGES (NUM_STAGES),
        .REG_ADDR_W (REG_ADDR_W),
        .LOAD_LAT   (LOAD_LAT),
        .ZERO_REG   (ZERO_REG),
        .SEL_W      (SEL_W)
    ) u_match_rn (
        .entries  (stage_reg),
        .src      (dec_rn),
        .sel      (sel_a),
        .load_hit (load_hit_a)
    );

    hazard_match #(
        .NUM_STAGES (NUM_STAGES),
        .REG_ADDR_W (REG_ADDR_W),
        .LOAD_LAT   (LOAD_LAT),
        .ZERO_REG   (ZERO_REG),
        .SEL_W      (SEL_W)
    ) u_match_rm (
        .entries  (stage_reg),
        .src      (dec_rm),
        .sel      (sel_b),
        .load_hit (load_hit_b)
    );

    // Source A is always a register; source B only counts when it is used.
    assign hazard    = load_hit_a || (dec_rm_used && load_hit_b);
    assign stall     = hazard && dec_valid && !flush;
    assign fwd_sel_a = dec_valid ? sel_a : '0;
    assign fwd_sel_b = (dec_valid && dec_rm_used) ? sel_b : '0;

    // Entry entering stage 1: the decode instruction, or a bubble when
    // stalled, flushed or empty.
    always_comb begin
        dec_entry       = '0;
        dec_entry.valid = dec_valid && !stall && !flush;
        dec_entry.rd    = HZ_RD_W'(dec_rd);
        dec_entry.wr    = dec_wr;
        dec_entry.load  = dec_load;
    end

    // Stage 1 captures the decode entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg[0] <= '0;
        end else begin
            stage_reg[0] <= dec_entry;
        end
    end

    generate
        for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_shift
            // Older stages simply advance; the last entry falls off the end.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_reg[gi] <= '0;
                end else begin
                    stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

`ifdef HAZARD_PERF_EN
    logic fwd_event;
    assign fwd_event = dec_valid && !stall && !flush &&
                       ((fwd_sel_a != '0) || (fwd_sel_b != '0));

    // Free-running, wrapping event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (stall) begin
                stall_count <= stall_count + 32'd1;
            end
            if (fwd_event) begin
                fwd_count <= fwd_count + 32'd1;
            end
        end
    end
`endif

endmodule
